// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 sequential multiplier, signed or unsigned, fixed WIDTH+1 cycle latency.
// Works on magnitudes and applies the result sign once at the end, so the
// most negative operand needs no special casing (its magnitude fits WIDTH bits).
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t               state;
    logic [WIDTH-1:0]     a_mag;
    logic [2*WIDTH-1:0]   acc;      // upper half: partial sum, lower half: remaining multiplier bits
    logic                 neg;
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step, prod_next;

    // Operand magnitudes, one shift-add step, and the signed final value
    always_comb begin
        a_abs     = (signed_mode && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
        b_abs     = (signed_mode && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, a_mag} & {(WIDTH+1){acc[0]}});
        acc_step  = {sum, acc[WIDTH-1:1]};
        // Negating zero yields zero, so no negative-zero artefact can appear
        prod_next = neg ? (~acc_step + 1'b1) : acc_step;
    end

    // Control FSM with registered busy/done/prod
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            prod  <= '0;
            acc   <= '0;
            cnt   <= '0;
            a_mag <= '0;
            neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_mag <= a_abs;
                        acc   <= {{WIDTH{1'b0}}, b_abs};
                        neg   <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    // Last step: publish the result so it is visible during FINISH
                    if (cnt == CW'(WIDTH - 1)) begin
                        prod  <= prod_next;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier at WIDTH=8 and WIDTH=64.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst;

    logic         s8, sm8;
    logic [7:0]   a8, b8;
    logic         busy8, done8;
    logic [15:0]  prod8;

    logic         s64, sm64;
    logic [63:0]  a64, b64;
    logic         busy64, done64;
    logic [127:0] prod64;

    int n_chk  = 0;
    int n_fail = 0;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8),
        .a_in(a8), .b_in(b8), .busy(busy8), .done(done8), .prod(prod8)
    );

    seq_multiplier #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .start(s64), .signed_mode(sm64),
        .a_in(a64), .b_in(b64), .busy(busy64), .done(done64), .prod(prod64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Combinational reference product truncated to 2*w bits
    function automatic logic [127:0] gold(input logic sm, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
        logic signed [127:0] sa, sb;
        logic [127:0] r, mask;
        if (sm) begin
            sa = $signed({64'd0, a} << (128 - w)) >>> (128 - w);
            sb = $signed({64'd0, b} << (128 - w)) >>> (128 - w);
        end else begin
            sa = {64'd0, a};
            sb = {64'd0, b};
        end
        r    = sa * sb;
        mask = (w >= 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
        return r & mask;
    endfunction

    // One 8-bit multiply; lat is cycles from start cycle to done (0 = timeout).
    // Inputs are scrambled after the start cycle; inj_k injects a start mid-flight.
    task automatic mul8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input int inj_k, input logic [7:0] ia, input logic [7:0] ib,
                        output logic [15:0] p, output int lat, output int busy_n);
        @(negedge clk);
        sm8 = sm; a8 = a; b8 = b; s8 = 1'b1;
        lat = 0; busy_n = 0; p = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            if (k == inj_k) begin
                s8 = 1'b1; a8 = ia; b8 = ib;
            end
            if (busy8) busy_n++;
            if (done8) begin
                lat = k; p = prod8;
                break;
            end
        end
        s8 = 1'b0;
    endtask

    task automatic mul64(input logic sm, input logic [63:0] a, input logic [63:0] b,
                         output logic [127:0] p, output int lat);
        @(negedge clk);
        sm64 = sm; a64 = a; b64 = b; s64 = 1'b1;
        lat = 0; p = '0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            s64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            if (done64) begin
                lat = k; p = prod64;
                break;
            end
        end
        s64 = 1'b0;
    endtask

    initial begin
        logic [15:0]  p8;
        logic [127:0] p64;
        logic [63:0]  ra, rb;
        logic         rsm;
        int lat, bn, dn;

        rst = 1'b1;
        s8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        s64 = 1'b0; sm64 = 1'b0; a64 = '0; b64 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy8", 128'(busy8), 128'd0);
        check("rst_done8", 128'(done8), 128'd0);
        check("rst_prod8", 128'(prod8), 128'd0);
        check("rst_busy64", 128'(busy64), 128'd0);
        check("rst_prod64", prod64, 128'd0);
        rst = 1'b0;

        // Basic unsigned: latency and busy window
        mul8(1'b0, 8'd13, 8'd11, 0, 8'd0, 8'd0, p8, lat, bn);
        check("u13x11_prod", 128'(p8), 128'h008F);
        check("u13x11_lat", 128'(lat), 128'd9);
        check("u13x11_busy", 128'(bn), 128'd9);
        @(negedge clk);
        check("done_pulse", 128'(done8), 128'd0);
        check("idle_busy", 128'(busy8), 128'd0);
        check("prod_hold", 128'(prod8), 128'h008F);

        // Signed corners
        mul8(1'b1, 8'h80, 8'h80, 0, 8'd0, 8'd0, p8, lat, bn);
        check("s_min_x_min", 128'(p8), 128'h4000);
        mul8(1'b1, 8'h80, 8'h01, 0, 8'd0, 8'd0, p8, lat, bn);
        check("s_min_x_1", 128'(p8), 128'hFF80);
        mul8(1'b1, 8'hF9, 8'h05, 0, 8'd0, 8'd0, p8, lat, bn);
        check("s_m7_x_5", 128'(p8), 128'hFFDD);
        mul8(1'b1, 8'hFF, 8'hFF, 0, 8'd0, 8'd0, p8, lat, bn);
        check("s_m1_x_m1", 128'(p8), 128'h0001);
        mul8(1'b0, 8'hFF, 8'hFF, 0, 8'd0, 8'd0, p8, lat, bn);
        check("u_ff_x_ff", 128'(p8), 128'hFE01);
        mul8(1'b1, 8'h00, 8'h5A, 0, 8'd0, 8'd0, p8, lat, bn);
        check("s_0_x_5a", 128'(p8), 128'h0000);
        mul8(1'b1, 8'h00, 8'h80, 0, 8'd0, 8'd0, p8, lat, bn);
        check("s_negzero", 128'(p8), 128'h0000);

        // Start while busy is ignored; back-to-back issue right after done
        mul8(1'b0, 8'd13, 8'd11, 3, 8'h22, 8'h33, p8, lat, bn);
        check("inj_prod", 128'(p8), 128'h008F);
        check("inj_lat", 128'(lat), 128'd9);
        mul8(1'b0, 8'd200, 8'd3, 0, 8'd0, 8'd0, p8, lat, bn);
        check("b2b_prod", 128'(p8), 128'h0258);
        check("b2b_lat", 128'(lat), 128'd9);

        // Reset 4 cycles into CALC aborts the multiply
        @(negedge clk);
        sm8 = 1'b0; a8 = 8'd9; b8 = 8'd9; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 128'(busy8), 128'd0);
        check("abort_done", 128'(done8), 128'd0);
        check("abort_prod", 128'(prod8), 128'd0);
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) dn++;
        end
        check("abort_no_done", 128'(dn), 128'd0);
        mul8(1'b1, 8'hF9, 8'h05, 0, 8'd0, 8'd0, p8, lat, bn);
        check("post_abort_prod", 128'(p8), 128'hFFDD);
        check("post_abort_lat", 128'(lat), 128'd9);

        // 64-bit directed corners
        mul64(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, p64, lat);
        check("w64_s_min_sq", p64, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
        check("w64_lat", 128'(lat), 128'd65);
        mul64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, p64, lat);
        check("w64_u_ones_sq", p64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        // 64-bit random against the reference model
        for (int i = 0; i < 1000; i++) begin
            rsm = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            mul64(rsm, ra, rb, p64, lat);
            check("w64_rand_prod", p64, gold(rsm, ra, rb, 64));
            check("w64_rand_lat", 128'(lat), 128'd65);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
